sw_debounce: RTL and testbench

Switch input conditioner that sits directly upstream of the 2-bit comparator board wrapper. It synchronises the raw slide-switch bus into the clock domain and debounces each bit independently. It then presents a stable `sw_clean` bus, which the wrapper splits into A = `sw_clean[3:2]` and B = `sw_clean[1:0]`. A one-cycle `sw_changed` strobe marks every accepted change, so downstream logic can latch or count comparisons.

---
 rtl/sw_debounce.sv | 74 +++++++
 tb/tb_sw_debounce.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus per-bit tick-based debounce
// for the slide-switch bus, with a one-cycle change strobe.
module sw_debounce #(
  parameter int WIDTH        = 4,
  parameter int DIV          = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             sw_changed,
  output logic             tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] sync_q;
  logic [PW-1:0]    pcnt;
  logic [PW-1:0]    pcnt_nxt;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] clean_nxt;
  logic [WIDTH-1:0] acc;

  always_comb begin
    pcnt_nxt = (pcnt == PMAX) ? '0 : pcnt + PW'(1);
  end

  // Any reversion to the accepted level aborts the count, tick or not.
  always_comb begin
    clean_nxt = sw_clean;
    acc       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      priority case (1'b1)
        sync_q[i] == sw_clean[i]: cnt_nxt[i] = '0;
        tick && (cnt[i] == CMAX): begin
          clean_nxt[i] = sync_q[i];
          cnt_nxt[i]   = '0;
          acc[i]       = 1'b1;
        end
        tick: cnt_nxt[i] = cnt[i] + CW'(1);
        default: ;
      endcase
    end
  end

  // tick is registered so it reads 0 in reset even when DIV is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= '0;
      sync_q     <= '0;
      pcnt       <= '0;
      tick       <= 1'b0;
      sw_clean   <= '0;
      sw_changed <= 1'b0;
      cnt        <= '{default: '0};
    end else begin
      s1         <= sw_raw;
      sync_q     <= s1;
      pcnt       <= pcnt_nxt;
      tick       <= (pcnt_nxt == PMAX);
      sw_clean   <= clean_nxt;
      sw_changed <= |acc;
      cnt        <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed checks of sync latency, debounce, glitch,
// bounce, prescaler quantisation and reset behaviour.
module tb_sw_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] raw_a, clean_a;
  logic       chg_a, tick_a;
  logic [3:0] raw_b, clean_b;
  logic       chg_b, tick_b;

  int n_chk = 0;
  int n_err = 0;
  int pa    = 0;

  sw_debounce #(.WIDTH(4), .DIV(1), .STABLE_TICKS(4)) u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (raw_a),
    .sw_clean   (clean_a),
    .sw_changed (chg_a),
    .tick       (tick_a)
  );

  sw_debounce #(.WIDTH(4), .DIV(3), .STABLE_TICKS(2)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (raw_b),
    .sw_clean   (clean_b),
    .sw_changed (chg_b),
    .tick       (tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
    if (chg_a) pa++;
  endtask

  task automatic watch(input int n, input logic [3:0] tgt,
                       output int at, output int ca);
    at = -1;
    ca = -1;
    for (int k = 1; k <= n; k++) begin
      edge1();
      if (ca < 0 && chg_a) ca = k;
      if (clean_a == tgt) begin
        at = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int at, ca, p0, tk, prev, cb, nt;
    int tp [2];
    logic [3:0] cl [15];
    logic       cg [15];

    rst_n = 1'b0;
    raw_a = 4'hf;
    raw_b = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clean_a", clean_a, 0);
    check("rst_chg_a", chg_a, 0);
    check("rst_tick_a", tick_a, 0);
    check("rst_clean_b", clean_b, 0);
    check("rst_tick_b", tick_b, 0);

    // power-up with switches high
    rst_n = 1'b1;
    p0 = pa;
    watch(10, 4'hf, at, ca);
    check("pwrup_at", at, 6);
    check("pwrup_chg_at", ca, 6);
    check("pwrup_pulses", pa - p0, 1);
    edge1();
    check("pwrup_1cyc", chg_a, 0);

    raw_a = 4'h0;
    watch(10, 4'h0, at, ca);
    check("fall_at", at, 6);

    // clean step
    raw_a = 4'b1010;
    p0 = pa;
    watch(10, 4'b1010, at, ca);
    check("step_at", at, 6);
    check("step_chg_at", ca, 6);
    check("step_pulses", pa - p0, 1);
    edge1();
    check("step_1cyc", chg_a, 0);

    raw_a = 4'h0;
    watch(10, 4'h0, at, ca);
    check("step_back_at", at, 6);

    // 3-cycle glitch
    p0 = pa;
    raw_a = 4'b0001;
    repeat (3) edge1();
    raw_a = 4'b0000;
    repeat (8) edge1();
    check("glitch_clean", clean_a, 0);
    check("glitch_pulses", pa - p0, 0);

    // 4-cycle pulse: accepted, then the fall accepted
    p0 = pa;
    raw_a = 4'b0001;
    repeat (4) edge1();
    raw_a = 4'b0000;
    watch(12, 4'b0001, at, ca);
    check("pulse4_rise_at", at, 2);
    watch(12, 4'b0000, at, ca);
    check("pulse4_fall_at", at, 4);
    check("pulse4_pulses", pa - p0, 2);

    // bit 2 bounces, bit 3 steps once
    p0 = pa;
    for (int k = 1; k <= 14; k++) begin
      raw_a = (k <= 2 || (k >= 5 && k <= 6) || k >= 9) ? 4'b1100 : 4'b1000;
      edge1();
      cl[k] = clean_a;
      cg[k] = chg_a;
    end
    check("bnc_e5", cl[5], 4'b0000);
    check("bnc_e6", cl[6], 4'b1000);
    check("bnc_chg6", cg[6], 1);
    check("bnc_e13", cl[13], 4'b1000);
    check("bnc_chg13", cg[13], 0);
    check("bnc_e14", cl[14], 4'b1100);
    check("bnc_chg14", cg[14], 1);
    check("bnc_pulses", pa - p0, 2);

    // prescaler DIV=3
    nt = 0;
    for (int k = 1; k <= 9; k++) begin
      edge1();
      if (tick_b) begin
        if (nt < 2) tp[nt] = k;
        nt++;
      end
    end
    check("pq_ticks", nt, 3);
    check("pq_period", tp[1] - tp[0], 3);

    raw_b = 4'b0010;
    at = -1;
    tk = 0;
    cb = 0;
    for (int k = 1; k <= 12; k++) begin
      prev = int'(tick_b);
      edge1();
      if (at < 0 && clean_b == 4'b0010) begin
        at = k;
        tk = prev;
        cb = int'(chg_b);
      end
    end
    check("pq_lat_range", (at >= 6 && at <= 8), 1);
    check("pq_on_tick", tk, 1);
    check("pq_chg", cb, 1);

    // reset with cnt[1] at 2 of 4
    raw_a = 4'b1110;
    repeat (4) edge1();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_clean", clean_a, 0);
    check("arst_chg", chg_a, 0);
    check("arst_tick", tick_a, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pa;
    watch(10, 4'b1110, at, ca);
    check("mrst_at", at, 6);
    check("mrst_chg_at", ca, 6);
    check("mrst_pulses", pa - p0, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
